// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register-hazard scoreboard.
//   REG_ID_W  : width of a unified register id ({fpr, index})
//   WAIT_W    : width of the decode result-latency field
//   RW_*      : destination / writeback class encodings
//   sb_state_t: flush-drain FSM states
package reg_scoreboard_pkg;

    localparam int unsigned REG_ID_W = 6;
    localparam int unsigned WAIT_W   = 5;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_GPR  = 2'b01;
    localparam logic [1:0] RW_FPR  = 2'b10;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_DRAIN,
        SB_ACK
    } sb_state_t;

endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: one saturating down-counter tracking the remaining result
// latency of a single register id.
//   clk, rstn : clock, asynchronous active-low reset
//   load      : load load_val this edge (wins over clear)
//   load_val  : latency to load
//   clear     : force to zero this edge (early writeback)
//   nz        : counter is nonzero
module sb_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic             nz
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign nz = (cnt != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-hazard scheduler beside decode. Tracks remaining
// result latency of every in-flight write to the 64-entry unified register
// space (gpr 0-31, fpr 32-63) and stalls RAW/WAW conflicts; provides a
// drain handshake for pipeline flushes.
//   clk, rstn                  : clock, asynchronous active-low reset
//   issue_valid/use_s/rs/use_t/rt/rw/rd/wait : decoded instruction
//   issue_ready, stall         : accept / stall indication (combinational)
//   wb_valid/wb_rw/wb_rd       : early completion, clears that id's counter
//   flush_req, flush_ack       : level drain request, one-cycle done pulse
//   busy                       : any counter nonzero
// Optional: define SB_STATS_EN to add stall_cycles / drain_cycles outputs.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NREG  = 64,
    parameter int unsigned CNT_W = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                issue_valid,
    input  logic                issue_use_s,
    input  logic [REG_ID_W-1:0] issue_rs,
    input  logic                issue_use_t,
    input  logic [REG_ID_W-1:0] issue_rt,
    input  logic [1:0]          issue_rw,
    input  logic [4:0]          issue_rd,
    input  logic [WAIT_W-1:0]   issue_wait,
    output logic                issue_ready,
    output logic                stall,
    input  logic                wb_valid,
    input  logic [1:0]          wb_rw,
    input  logic [4:0]          wb_rd,
    input  logic                flush_req,
    output logic                flush_ack,
    output logic                busy
`ifdef SB_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         drain_cycles
`endif
);

    sb_state_t           state;
    logic [NREG-1:0]     nz;
    logic [NREG-1:0]     load;
    logic [NREG-1:0]     clr;
    logic [REG_ID_W-1:0] dest_id;
    logic [REG_ID_W-1:0] wb_id;
    logic                dest_valid;
    logic                wb_en;
    logic                load_en;
    logic                raw_s;
    logic                raw_t;
    logic                waw;
    logic                accept;
    logic [CNT_W-1:0]    load_val;

    // Class 11 is reserved and behaves like "no destination".
    assign dest_valid = (issue_rw == RW_GPR) || (issue_rw == RW_FPR);
    assign dest_id    = {issue_rw == RW_FPR, issue_rd};
    assign wb_en      = wb_valid && ((wb_rw == RW_GPR) || (wb_rw == RW_FPR));
    assign wb_id      = {wb_rw == RW_FPR, wb_rd};

    assign raw_s = issue_use_s && nz[issue_rs];
    assign raw_t = issue_use_t && nz[issue_rt];
    assign waw   = dest_valid  && nz[dest_id];

    assign issue_ready = (state == SB_IDLE) && !(raw_s || raw_t || waw);
    assign stall       = issue_valid && !issue_ready;
    assign accept      = issue_valid && issue_ready;
    assign busy        = |nz;

    // Zero latency is forwardable next cycle, so it arms no counter.
    assign load_en  = accept && dest_valid && (issue_wait != '0);
    assign load_val = CNT_W'(issue_wait);

    always_comb begin
        load = '0;
        clr  = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            load[i] = load_en && (dest_id == REG_ID_W'(i));
            clr[i]  = wb_en   && (wb_id   == REG_ID_W'(i));
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rstn     (rstn),
            .load     (load[g]),
            .load_val (load_val),
            .clear    (clr[g]),
            .nz       (nz[g])
        );
    end

    // flush_ack is registered: it is high exactly while the FSM sits in ACK.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= SB_IDLE;
            flush_ack <= 1'b0;
        end else begin
            case (state)
                SB_IDLE: begin
                    flush_ack <= 1'b0;
                    if (flush_req) begin
                        state <= SB_DRAIN;
                    end
                end
                SB_DRAIN: begin
                    if (!busy) begin
                        state     <= SB_ACK;
                        flush_ack <= 1'b1;
                    end
                end
                SB_ACK: begin
                    state     <= SB_IDLE;
                    flush_ack <= 1'b0;
                end
                default: begin
                    state     <= SB_IDLE;
                    flush_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef SB_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
            drain_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state == SB_DRAIN) && (drain_cycles != '1)) begin
                drain_cycles <= drain_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-hazard scheduler sitting beside the decode stage.
- Tracks the remaining result latency of every in-flight write to the unified 64-entry register space: gpr ids 0-31, fpr ids 32-63, bit 5 = fpr.
- Decides each cycle whether the decoded instruction may issue; stalls it on RAW and WAW conflicts with multi-cycle producers (loads, FPU add/sub/inv/sqrt).
- Provides a drain handshake for pipeline flushes.

Parameters:
- NREG, 64, number of tracked register ids (gpr + fpr).
- CNT_W, 5, width of each latency counter; matches the decode wait_time width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset: asynchronous, active-low.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_use_s  in  1  instruction reads source s.
- issue_rs  in  6  source s id ({fpr, index}).
- issue_use_t  in  1  instruction reads source t.
- issue_rt  in  6  source t id.
- issue_rw  in  2  destination class: 00 none, 01 gpr, 10 fpr, 11 reserved (treated as none).
- issue_rd  in  5  destination index.
- issue_wait  in  5  result latency in cycles; 0 = forwardable next cycle.
- issue_ready  out  1  instruction accepted this cycle.
- stall  out  1  issue_valid & ~issue_ready.
- wb_valid  in  1  early completion from writeback.
- wb_rw  in  2  writeback class (01 gpr, 10 fpr).
- wb_rd  in  5  writeback index.
- flush_req  in  1  level request to drain all pending writes.
- flush_ack  out  1  one-cycle pulse when the drain completes.
- busy  out  1  any counter nonzero.

Behaviour:
- Reset (async, rstn=0): all counters 0, FSM in IDLE.
  - Output values during reset: issue_ready=1, flush_ack=0, busy=0. stall follows issue_valid & ~issue_ready, so it is 0.
- Destination id: {issue_rw==10, issue_rd}; valid only for rw 01 or 10. Register id 0 is tracked like any other id.
- Hazard terms, all combinational from current counter values:
  - raw_s = use_s & cnt[rs] != 0.
  - raw_t = use_t & cnt[rt] != 0.
  - waw = dest valid & cnt[dest] != 0.
- issue_ready = state==IDLE & ~(raw_s | raw_t | waw). It is combinational, with zero-cycle latency to decode.
- Accept = issue_valid & issue_ready.
  - On accept with a valid dest and issue_wait != 0: cnt[dest] <= issue_wait at the clock edge.
  - issue_wait == 0 sets nothing.
- Every edge, each counter not being loaded decrements if nonzero and saturates at 0.
- Example: accept with wait 2 at edge k. cnt reads 2 after edge k and 1 after edge k+1. A consumer can be accepted in the cycle after edge k+2.
- wb_valid with class 01/10 forces cnt[wb id] <= 0.
  - If the same edge also loads that id from an accept, the load wins.
- FSM:
  - IDLE: flush_req=1 -> DRAIN.
  - DRAIN: issue_ready=0; counters keep decrementing and accepting wb clears.
  - DRAIN: when busy==0 -> ACK.
  - ACK: flush_ack=1 for one cycle -> IDLE, regardless of flush_req.
  - flush_req held high after ACK starts a new drain. When busy is already 0 the drain takes two cycles: IDLE -> DRAIN -> ACK.
- Reset asserted mid-DRAIN returns to IDLE with counters cleared. No flush_ack is produced.
- busy = OR of all counters != 0, registered-free (combinational).

Optional Feature:
- Macro: SB_STATS_EN.
- Defined:
  - Adds output stall_cycles [31:0]. It increments on every cycle with stall=1 and saturates at 32'hffffffff.
  - Adds output drain_cycles [31:0]. It counts cycles spent in DRAIN and also saturates.
  - Both counters clear on reset.
- Undefined: neither port exists and no counter logic is present.

Decomposition:
- Package constant gains:
  - REG_ID_W=6.
  - WAIT_W=5.
  - RW_NONE=2'b00, RW_GPR=2'b01, RW_FPR=2'b10.
  - Typedef sb_state_t {SB_IDLE, SB_DRAIN, SB_ACK}.
- One sub-module, sb_counter: a single CNT_W saturating down-counter with load, clear and nonzero flag. It is instantiated NREG times via generate.

Test Plan:
- Load-use: accept rw=01 rd=5 wait=2. Next cycle, use_s rs=5 -> stall=1 for 2 cycles; issue_ready=1 on the 3rd cycle.
- FPU WAW: accept rw=10 rd=3 wait=5. Then rw=10 rd=3 wait=0 -> stalled 5 cycles.
  - In the same window, rs=6'd3 (gpr 3) with use_s=1 -> not stalled.
- Early completion: accept fpr 7 wait=5. Assert wb_valid wb_rw=10 wb_rd=7 one cycle later -> consumer of id 39 ready next cycle.
- Load/clear collision: accept rd=9 wait=3 on the same edge as wb clear of gpr 9 -> cnt[9]=3 afterwards.
- Flush: pending wait=4, assert flush_req -> issue_ready=0. flush_ack pulses exactly 1 cycle after busy drops, then issue_ready=1.
- Async reset mid-DRAIN:
  - Expect: counters 0, flush_ack never pulses, issue_ready=1 while rstn=0.
  - With SB_STATS_EN, stall_cycles reads 0.
